// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

  function automatic logic isDivOp(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational sign restoration, word selection and divide special cases
// applied to the raw magnitude results of the iterative datapath.
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        Funct3,
  input  logic [2*XLEN-1:0] Product,
  input  logic [XLEN-1:0]   Quotient,
  input  logic [XLEN-1:0]   Remainder,
  input  logic              NegA,
  input  logic              NegB,
  input  logic              DivZero,
  input  logic              DivOvf,
  output logic [XLEN-1:0]   Result
);

  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN-1:0]   quotSigned;
  logic [XLEN-1:0]   remSigned;

  // Unsigned operands never set their neg flag, so one rule covers all variants.
  assign prodSigned = (NegA ^ NegB) ? -Product  : Product;
  assign quotSigned = (NegA ^ NegB) ? -Quotient : Quotient;
  assign remSigned  = NegA          ? -Remainder : Remainder;

  always_comb begin
    Result = '0;
    case (Funct3)
      F3_MUL:                        Result = prodSigned[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  Result = prodSigned[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (DivZero)     Result = '1;
        else if (DivOvf) Result = {1'b1, {(XLEN-1){1'b0}}};
        else             Result = quotSigned;
      end
      // With a zero divisor the remainder magnitude equals the dividend's,
      // and restoring its sign returns the dividend unchanged.
      default:         Result = DivOvf ? '0 : remSigned;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: fixed 34-cycle shift-add multiply or
// restoring divide, returning a one-cycle Done pulse with Result and RdOut.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  input  logic [4:0]      RdIn,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic [4:0]      RdOut
);

  muldiv_state_t   state;
  logic [4:0]      iterCnt;
  logic [2:0]      f3Q;
  logic [4:0]      rdQ;
  logic            negA, negB, divZero, divOvf;
  logic [XLEN-1:0] opB;
  logic [XLEN-1:0] accHi;
  logic [XLEN-1:0] accLo;

  logic            capSignedA, capSignedB, capNegA, capNegB;
  logic [XLEN-1:0] magA, magB;
  logic [XLEN:0]   mulSum;
  logic [XLEN:0]   divShift;
  logic [XLEN:0]   divDiff;
  logic            divFits;
  logic [XLEN-1:0] fixResult;

  assign capSignedA = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
                      (Funct3 == F3_DIV)  || (Funct3 == F3_REM);
  assign capSignedB = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
  assign capNegA    = capSignedA && Operand1[XLEN-1];
  assign capNegB    = capSignedB && Operand2[XLEN-1];
  assign magA       = capNegA ? -Operand1 : Operand1;
  assign magB       = capNegB ? -Operand2 : Operand2;

  // Multiply keeps {accHi, accLo} as the product with the multiplier in accLo
  // shifting out; divide keeps the remainder in accHi and the dividend/quotient in accLo.
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
  assign divShift = {accHi, accLo[XLEN-1]};
  assign divDiff  = divShift - {1'b0, opB};
  assign divFits  = ~divDiff[XLEN];

  muldiv_fixup #(.XLEN(XLEN)) uFixup (
    .Funct3    (f3Q),
    .Product   ({accHi, accLo}),
    .Quotient  (accLo),
    .Remainder (accHi),
    .NegA      (negA),
    .NegB      (negB),
    .DivZero   (divZero),
    .DivOvf    (divOvf),
    .Result    (fixResult)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      iterCnt <= '0;
      f3Q     <= '0;
      rdQ     <= '0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      divZero <= 1'b0;
      divOvf  <= 1'b0;
      opB     <= '0;
      accHi   <= '0;
      accLo   <= '0;
      Result  <= '0;
      RdOut   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            f3Q     <= Funct3;
            rdQ     <= RdIn;
            negA    <= capNegA;
            negB    <= capNegB;
            divZero <= (Operand2 == '0);
            divOvf  <= ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                       (Operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (Operand2 == '1);
            opB     <= magB;
            accHi   <= '0;
            accLo   <= magA;
            iterCnt <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (isDivOp(f3Q)) begin
            accHi <= divFits ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
            accLo <= {accLo[XLEN-2:0], divFits};
          end else begin
            accHi <= mulSum[XLEN:1];
            accLo <= {mulSum[0], accLo[XLEN-1:1]};
          end
          iterCnt <= iterCnt + 5'd1;
          if (iterCnt == 5'(MULDIV_ITERS - 1)) state <= FIX;
        end
        FIX: begin
          Result <= fixResult;
          RdOut  <= rdQ;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an expected-result scoreboard queue.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] Operand1, Operand2;
  logic [4:0]  RdIn;
  logic        Busy, Done;
  logic [31:0] Result;
  logic [4:0]  RdOut;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   sc     = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Funct3   (Funct3),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .RdIn     (RdIn),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .RdOut    (RdOut)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    case (f3)
      F3_MUL:    begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      F3_MULH:   begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
      F3_MULHSU: begin sp = longint'(sa) * longint'({32'b0, b}); up = sp; return up[63:32]; end
      F3_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      F3_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic toCycle(input int c);
    do @(negedge Clk); while (cycle < c);
  endtask

  task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expRes);
    exp_t e;
    @(negedge Clk);
    Funct3   = f3;
    Operand1 = a;
    Operand2 = b;
    RdIn     = rd;
    Start    = 1'b1;
    e.res = expRes;
    e.rd  = rd;
    sbQ.push_back(e);
    @(posedge Clk);
    #1;
    sc       = cycle;
    Start    = 1'b0;
    Operand1 = $urandom;
    Operand2 = $urandom;
    RdIn     = 5'($urandom);
    Funct3   = 3'($urandom);
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'(sbQ.size()), 32'd1);
    end else begin
      e = sbQ.pop_front();
      chk({tag, " latency"}, 32'(cycle - sc), 32'd33);
      chk({tag, " Result"}, Result, e.res);
      chk({tag, " RdOut"}, {27'b0, RdOut}, {27'b0, e.rd});
    end
  endtask

  task automatic waitDone(input string tag, output int busyCnt);
    int n;
    logic found;
    n       = 0;
    found   = 1'b0;
    busyCnt = 0;
    while (!found && n < 40) begin
      @(negedge Clk);
      n++;
      if (Busy) busyCnt++;
      if (Done) found = 1'b1;
    end
    chk({tag, " Done seen"}, {31'b0, found}, 32'd1);
    if (found) popCheck(tag);
    else if (sbQ.size() != 0) void'(sbQ.pop_front());
    @(negedge Clk);
    chk({tag, " Done cleared"}, {31'b0, Done}, 32'd0);
    chk({tag, " Busy cleared"}, {31'b0, Busy}, 32'd0);
  endtask

  initial begin
    int   busyCnt;
    int   doneCnt;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    Rst_n = 1'b0; Start = 1'b0; Funct3 = '0; Operand1 = '0; Operand2 = '0; RdIn = '0;
    repeat (3) @(negedge Clk);
    chk("reset Busy", {31'b0, Busy}, 32'd0);
    chk("reset Done", {31'b0, Done}, 32'd0);
    chk("reset Result", Result, 32'd0);
    chk("reset RdOut", {27'b0, RdOut}, 32'd0);
    Rst_n = 1'b1;

    startOp(F3_MUL, 32'd7, 32'd6, 5'd5, 32'd42);
    chk("MUL Busy after start", {31'b0, Busy}, 32'd1);
    waitDone("MUL 7x6", busyCnt);
    chk("MUL busy cycles", 32'(busyCnt), 32'd34);

    startOp(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    waitDone("MULH", busyCnt);
    startOp(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
    waitDone("MULHSU", busyCnt);
    startOp(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    waitDone("MULHU", busyCnt);
    startOp(F3_DIV,  -32'sd7, 32'd2, 5'd4, 32'hFFFF_FFFD);
    waitDone("DIV -7/2", busyCnt);
    startOp(F3_REM,  -32'sd7, 32'd2, 5'd6, 32'hFFFF_FFFF);
    waitDone("REM -7/2", busyCnt);
    startOp(F3_DIVU, 32'd100, 32'd7, 5'd7, 32'd14);
    waitDone("DIVU 100/7", busyCnt);
    startOp(F3_REMU, 32'd100, 32'd7, 5'd8, 32'd2);
    waitDone("REMU 100/7", busyCnt);
    startOp(F3_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
    waitDone("DIVU by zero", busyCnt);
    startOp(F3_REMU, 32'd5, 32'd0, 5'd11, 32'd5);
    waitDone("REMU by zero", busyCnt);
    startOp(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    waitDone("DIV overflow", busyCnt);
    startOp(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0);
    waitDone("REM overflow", busyCnt);
    startOp(F3_DIV, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFFF);
    waitDone("DIV neg by zero", busyCnt);
    startOp(F3_REM, 32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFF9);
    waitDone("REM neg by zero", busyCnt);

    for (int i = 0; i < 8; i++) begin
      rf = 3'(i);
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom >> (i * 3);
      startOp(rf, ra, rb, 5'(i + 16), model(rf, ra, rb));
      waitDone("random op", busyCnt);
    end

    // Start pulses while busy must be ignored.
    startOp(F3_MUL, 32'd3, 32'd4, 5'd9, 32'd12);
    toCycle(sc + 4);
    Funct3 = F3_DIVU; Operand1 = 32'd100; Operand2 = 32'd7; RdIn = 5'd1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    toCycle(sc + 32);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("ignore Done pulse", {31'b0, Done}, 32'd1);
    popCheck("ignore first op");
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) doneCnt++;
    end
    chk("ignore no extra Done", 32'(doneCnt), 32'd0);

    // Reset mid-operation aborts with no Done.
    startOp(F3_MUL, 32'd9, 32'd9, 5'd3, 32'd81);
    toCycle(sc + 9);
    Rst_n = 1'b0;
    #1;
    chk("abort Busy", {31'b0, Busy}, 32'd0);
    chk("abort Done", {31'b0, Done}, 32'd0);
    chk("abort Result", Result, 32'd0);
    chk("abort RdOut", {27'b0, RdOut}, 32'd0);
    sbQ.delete();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done || Busy) doneCnt++;
    end
    chk("abort no Done", 32'(doneCnt), 32'd0);
    startOp(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31,
            model(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));
    waitDone("after reset", busyCnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit implementing the RV32M operations for the CPU. It sits directly downstream of the register file: it takes the two register read operands plus the destination register index, then runs a fixed-latency shift-add multiply or restoring divide. It returns a one-cycle `Done` pulse carrying `Result` and `RdOut`, which drive the register file's `WriteData` and `WriteRegister` with `RegWrite` asserted.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `Clk`  in  1  clock. One clock; all state is updated on the rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  request; sampled only when idle.
- `Funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `Operand1`  in  32  rs1 value (multiplicand/dividend).
- `Operand2`  in  32  rs2 value (multiplier/divisor).
- `RdIn`  in  5  destination register index.
- `Busy`  out  1  high while an operation is in flight.
- `Done`  out  1  one-cycle pulse; `Result` and `RdOut` are valid in that cycle.
- `Result`  out  32  operation result.
- `RdOut`  out  5  captured `RdIn`.

## Operation
FSM states:
- IDLE
  - `Start`=1 captures `Funct3`, `Operand1`, `Operand2` and `RdIn`.
  - Signed operands are converted to magnitudes, with the sign flags saved.
  - Iteration counter is cleared; go to CALC.
  - Inputs may change freely after capture.
- CALC
  - One iteration per cycle, 32 iterations (counter 0..31).
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring, 1 quotient bit per cycle, 33-bit partial remainder.
  - After iteration 31, go to FIX.
- FIX
  - Negate product/quotient/remainder per the saved signs.
    - MULHSU: only `Operand1` is signed.
    - Remainder takes the dividend's sign.
  - Select the low word (MUL) or high word (MULH*).
  - Apply divide special cases:
    - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
    - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM returns 0.
  - Register `Result` and `RdOut`; go to DONE.
- DONE
  - `Done`=1 for this single cycle; go to IDLE.

Rules:
- Special cases do not shorten latency; latency is fixed for every opcode and operand value.
- `Start` while `Busy`=1 (CALC/FIX/DONE) is ignored; no queueing.
- `Result`/`RdOut` hold their last value after DONE until the next FIX.
- All arithmetic is modulo 2^32 per word. Negation is two's complement of the full-width magnitude, so |0x80000000| = 0x80000000 as unsigned.

## Timing
- Reset values:
  - State IDLE.
  - `Busy`=0, `Done`=0, `Result`=0, `RdOut`=0.
  - Internal accumulators/counter = 0.
- Reset mid-operation aborts immediately; no `Done` is ever produced for the aborted request.
- `Start` sampled at edge N:
  - `Busy`=1 from after edge N.
  - Iterations occur at edges N+1..N+32.
  - FIX result is registered at edge N+33.
  - `Done`=1 between edges N+33 and N+34.
  - `Busy`=0 after edge N+34.
- Back-to-back operations: the earliest next `Start` is sampled at edge N+34, so throughput is one operation per 34 cycles.
- `Busy` is a registered output decoded from state (`Busy` = state≠IDLE); `Done` = (state==DONE).
- No combinational path from any input to any output.

## Structure
- Shared package `muldiv_pkg` holds:
  - `Funct3` encoding constants (`F3_MUL`..`F3_REMU`).
  - State enum `muldiv_state_t` {IDLE, CALC, FIX, DONE}.
  - `MULDIV_ITERS` = 32.
- One sub-module is natural: `muldiv_fixup`, purely combinational. It takes the raw magnitude results, sign flags, divide-by-zero/overflow flags and `Funct3`, and produces the final 32-bit value.
- The FSM, counter and iteration datapath stay in `muldiv_unit`.

## Test plan
- MUL: `Operand1`=7, `Operand2`=6, `RdIn`=5 → `Done` exactly 33 edges after `Start`, `Result`=42, `RdOut`=5, `Busy` high for 34 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. Latency still 33.
- `Start` pulsed at edges N+5 and N+33 with different operands → ignored; the single `Done` carries the first operation's result; operands changed after edge N do not affect `Result`.
- `Rst_n` asserted at edge N+10 → `Busy`/`Done`/`Result`/`RdOut` go to 0 immediately; no `Done` follows. A new `Start` after release completes normally.
